// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// -----------------------------------------------------------------------------
// ps2_mouse_packet_decoder_pkg
//   Shared definitions for the PS/2 mouse back end: framing FSM state
//   encodings, PS/2 byte-0 bit positions, Kempston button bit positions,
//   the packet-update record and helpers that decode byte 0 and scale one
//   movement axis.
// -----------------------------------------------------------------------------
package ps2_mouse_packet_decoder_pkg;

    // Framing FSM states (byte index expected next).
    localparam logic [1:0] ST_B0 = 2'd0;
    localparam logic [1:0] ST_B1 = 2'd1;
    localparam logic [1:0] ST_B2 = 2'd2;
    localparam logic [1:0] ST_B3 = 2'd3;

    // PS/2 byte-0 bit positions.
    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_MID   = 2;
    localparam int B0_SYNC  = 3;
    localparam int B0_XS    = 4;
    localparam int B0_YS    = 5;
    localparam int B0_XO    = 6;
    localparam int B0_YO    = 7;

    // Kempston button byte bit positions (buttons active-low).
    localparam int KM_RIGHT = 0;
    localparam int KM_LEFT  = 1;
    localparam int KM_MID   = 2;
    localparam int KM_ONE   = 3;

    // Byte-0 fields kept while the rest of a packet arrives.
    typedef struct packed {
        logic       yo;
        logic       xo;
        logic       ys;
        logic       xs;
        logic       mid;
        logic       right;
        logic       left;
    } hdr_t;

    // Fully decoded packet, applied to the accumulators one cycle later.
    typedef struct packed {
        logic [7:0] dx;
        logic [7:0] dy;
        logic [3:0] dw;
        logic       mid;
        logic       right;
        logic       left;
    } pkt_update_t;

    function automatic hdr_t header_from_byte(input logic [7:0] b);
        hdr_t h;
        h.yo    = b[B0_YO];
        h.xo    = b[B0_XO];
        h.ys    = b[B0_YS];
        h.xs    = b[B0_XS];
        h.mid   = b[B0_MID];
        h.right = b[B0_RIGHT];
        h.left  = b[B0_LEFT];
        return h;
    endfunction

    // 9-bit signed delta, zeroed on axis overflow, divided by 2**shift with
    // an arithmetic shift (floor), truncated to the 8-bit accumulator width.
    function automatic logic [7:0] scaled_delta(input logic sign, input logic [7:0] mag,
                                                input logic ovf, input int shift);
        logic signed [8:0] d;
        d = ovf ? 9'sd0 : $signed({sign, mag});
        d = d >>> shift;
        return d[7:0];
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// -----------------------------------------------------------------------------
// ps2_byte_fifo
//   Small show-ahead FIFO for raw PS/2 bytes.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push, din     write strobe and data (ignored when full unless popping)
//     pop           discard head (ignored when empty)
//     dout          head word, zero when empty
//     count         words held (0 .. 2**AW)
//     full, empty   status
// -----------------------------------------------------------------------------
module ps2_byte_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// -----------------------------------------------------------------------------
// ps2_mouse_packet_decoder
//   Frames 3-byte (standard) or 4-byte (wheel) PS/2 mouse packets from the
//   received-byte stream, accumulates Kempston X/Y/wheel and buttons, and
//   buffers every raw byte in a FIFO for the MOUSEDATA register.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   B0    | waiting for byte 0 (must have sync bit set)
//   B1    | byte 0 held, waiting for X movement byte
//   B2    | waiting for Y movement byte (last byte in 3-byte mode)
//   B3    | waiting for wheel byte (4-byte mode only)
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     rx_data/rx_valid  received byte and its one-cycle strobe
//     wheel_mode        1 = 4-byte packets, sampled when byte 0 is accepted
//     fifo_pop          discard FIFO head
//     status_clr        clear sticky flags (a same-cycle set wins)
//     fifo_dout         FIFO head, 8'h00 when empty
//     fifo_count        bytes held
//     fifo_overflow     sticky: byte dropped on full FIFO
//     sync_error        sticky: bad byte 0 or mid-packet timeout
//     packet_strobe     one-cycle pulse when Kempston outputs change
//     kmouse_x/y        accumulated position, wraps mod 256
//     kmouse_buttons    {wheel[3:0], 1, ~mid, ~left, ~right}
// -----------------------------------------------------------------------------
module ps2_mouse_packet_decoder
    import ps2_mouse_packet_decoder_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int DIV_SHIFT      = 0,
    parameter int TIMEOUT_CYCLES = 56000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               wheel_mode,
    input  logic               fifo_pop,
    input  logic               status_clr,
    output logic [7:0]         fifo_dout,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               fifo_overflow,
    output logic               sync_error,
    output logic               packet_strobe,
    output logic [7:0]         kmouse_x,
    output logic [7:0]         kmouse_y,
    output logic [7:0]         kmouse_buttons
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT_CYCLES);

    logic [1:0]     state;
    hdr_t           hdr_q;
    logic           wm_q;
    logic [7:0]     b1_q;
    logic [7:0]     b2_q;
    logic [TW-1:0]  timer;

    pkt_update_t    upd_next;
    pkt_update_t    upd_q;
    logic           upd_pending;

    logic [7:0]     x_q;
    logic [7:0]     y_q;
    logic [3:0]     wheel_q;
    logic           left_q;
    logic           right_q;
    logic           mid_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_drop;

    logic           b0_bad;
    logic           timeout_hit;
    logic           pkt_done;

    ps2_byte_fifo #(
        .AW (FIFO_AW),
        .W  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_drop = rx_valid && fifo_full && !(fifo_pop && !fifo_empty);

    assign b0_bad      = rx_valid && (state == ST_B0) && !rx_data[B0_SYNC];
    // A byte arriving on the terminal cycle keeps the packet alive.
    assign timeout_hit = !rx_valid && (state != ST_B0) && (timer == TIMER_LAST);
    assign pkt_done    = rx_valid && (((state == ST_B2) && !wm_q) || (state == ST_B3));

    always_comb begin
        upd_next       = '0;
        upd_next.dx    = scaled_delta(hdr_q.xs, b1_q, hdr_q.xo, DIV_SHIFT);
        upd_next.dy    = scaled_delta(hdr_q.ys, (state == ST_B2) ? rx_data : b2_q,
                                      hdr_q.yo, DIV_SHIFT);
        upd_next.dw    = (state == ST_B3) ? rx_data[3:0] : 4'h0;
        upd_next.mid   = hdr_q.mid;
        upd_next.right = hdr_q.right;
        upd_next.left  = hdr_q.left;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_B0;
            hdr_q <= '0;
            wm_q  <= 1'b0;
            b1_q  <= 8'h00;
            b2_q  <= 8'h00;
        end else if (timeout_hit) begin
            state <= ST_B0;
        end else if (rx_valid) begin
            case (state)
                ST_B0: begin
                    if (rx_data[B0_SYNC]) begin
                        hdr_q <= header_from_byte(rx_data);
                        wm_q  <= wheel_mode;
                        state <= ST_B1;
                    end
                end
                ST_B1: begin
                    b1_q  <= rx_data;
                    state <= ST_B2;
                end
                ST_B2: begin
                    b2_q  <= rx_data;
                    state <= wm_q ? ST_B3 : ST_B0;
                end
                ST_B3: begin
                    state <= ST_B0;
                end
                default: begin
                    state <= ST_B0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (rx_valid) begin
            timer <= '0;
        end else if (timeout_hit) begin
            timer <= TIMER_SAT;
        end else if (state != ST_B0) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_pending   <= 1'b0;
            upd_q         <= '0;
            packet_strobe <= 1'b0;
            x_q           <= 8'h00;
            y_q           <= 8'h00;
            wheel_q       <= 4'h0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            mid_q         <= 1'b0;
        end else begin
            packet_strobe <= upd_pending;
            upd_pending   <= pkt_done;
            if (pkt_done) begin
                upd_q <= upd_next;
            end
            if (upd_pending) begin
                x_q     <= x_q + upd_q.dx;
                y_q     <= y_q + upd_q.dy;
                // PS/2 reports scroll-up as negative; Kempston counts it up.
                wheel_q <= wheel_q - upd_q.dw;
                left_q  <= upd_q.left;
                right_q <= upd_q.right;
                mid_q   <= upd_q.mid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_error    <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            if (b0_bad || timeout_hit) begin
                sync_error <= 1'b1;
            end else if (status_clr) begin
                sync_error <= 1'b0;
            end
            if (fifo_drop) begin
                fifo_overflow <= 1'b1;
            end else if (status_clr) begin
                fifo_overflow <= 1'b0;
            end
        end
    end

    assign kmouse_x = x_q;
    assign kmouse_y = y_q;

    always_comb begin
        kmouse_buttons           = 8'h00;
        kmouse_buttons[7:4]      = wheel_q;
        kmouse_buttons[KM_ONE]   = 1'b1;
        kmouse_buttons[KM_MID]   = ~mid_q;
        kmouse_buttons[KM_LEFT]  = ~left_q;
        kmouse_buttons[KM_RIGHT] = ~right_q;
    end

endmodule
